// File: rtl/bpred_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bpred_pkg
// Description : Shared types and constants for the branch-prediction resolve
//               block. Defines the in-flight entry layout and the default
//               in-flight buffer depth.
// Revision    : 1.0 - initial release
// ============================================================================
package bpred_pkg;

    // Default number of in-flight predicted branches (power of two, >= 2).
    localparam int unsigned c_depth = 4;

    // One in-flight predicted branch: fetch PC, predicted direction and
    // predicted taken target.
    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] target;
    } bp_entry_t;

endpackage : bpred_pkg
`default_nettype wire

// File: rtl/bpred_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bpred_fifo
// Description : Circular FIFO of bp_entry_t holding predicted branches in
//               program order. Head entry is visible combinationally.
//   clk       : clock
//   reset     : asynchronous active-low reset
//   push      : write push_data at the tail (ignored when full unless popping)
//   push_data : entry to store
//   pop       : retire the head entry (ignored when empty)
//   flush     : discard every entry (head = tail, count = 0); wins over
//               push/pop
//   head_data : oldest stored entry
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module bpred_fifo
    import bpred_pkg::*;
#(
    parameter int unsigned DEPTH = c_depth
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  bp_entry_t                push_data,
    input  logic                     pop,
    input  logic                     flush,
    output bp_entry_t                head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned            c_ptr_w    = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0]     c_ptr_one  = 1;
    localparam logic [c_ptr_w:0]       c_cnt_one  = 1;
    localparam logic [c_ptr_w:0]       c_cnt_full = (c_ptr_w + 1)'(DEPTH);

    bp_entry_t          r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_ptr_w:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_rd;

    assign w_full  = (r_count == c_cnt_full);
    assign w_empty = (r_count == '0);

    // When full, a write is only legal alongside a pop: the freed head slot
    // is the one the tail points at, and head_data is read before the edge.
    assign w_wr = push && (!w_full || pop) && !flush;
    assign w_rd = pop && !w_empty && !flush;

    // Pointer widths equal log2(DEPTH), so natural overflow gives the wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (w_wr) r_tail <= r_tail + c_ptr_one;
            if (w_rd) r_head <= r_head + c_ptr_one;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_tail] <= push_data;
    end

    assign head_data = r_mem[r_head];
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;

endmodule : bpred_fifo
`default_nettype wire

// File: rtl/bpred_resolve.sv
`default_nettype none
// ============================================================================
// Module      : bpred_resolve
// Description : Tracks predicted conditional branches from fetch until they
//               resolve, compares prediction with outcome, trains the
//               predictor, raises a redirect on mispredict and keeps
//               resolution statistics.
//   clk, reset              : clock, asynchronous active-low reset
//   push/push_pc/push_pred/push_target : branch fetched with its prediction
//   res_valid/res_taken/res_target     : outcome of the oldest in-flight branch
//   full, empty             : in-flight buffer status
//   update_en/pc/taken      : registered predictor training strobe
//   redirect/redirect_pc    : registered mispredict redirect
//   branch_cnt, mispred_cnt : saturating statistics counters
//   err_overflow/underflow  : sticky protocol-error flags
// Revision    : 1.0 - initial release
// ============================================================================
module bpred_resolve
    import bpred_pkg::*;
#(
    parameter int unsigned DEPTH = c_depth,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [31:0]      push_pc,
    input  logic             push_pred,
    input  logic [31:0]      push_target,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [31:0]      res_target,
    output logic             full,
    output logic             empty,
    output logic             update_en,
    output logic [31:0]      update_pc,
    output logic             update_taken,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic             err_overflow,
    output logic             err_underflow
);

    localparam int unsigned      c_cnt_w   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_stat_one = 1;

    bp_entry_t          w_head;
    bp_entry_t          w_push_entry;
    logic               w_full;
    logic               w_empty;
    logic [c_cnt_w-1:0] w_count;
    logic               w_pop;
    logic               w_mis;
    logic               w_push_ok;
    logic               w_overflow;
    logic               w_underflow;
    logic [31:0]        w_redirect_pc;

    logic               r_update_en;
    logic [31:0]        r_update_pc;
    logic               r_update_taken;
    logic               r_redirect;
    logic [31:0]        r_redirect_pc;
    logic [CNT_W-1:0]   r_branch_cnt;
    logic [CNT_W-1:0]   r_mispred_cnt;
    logic               r_err_overflow;
    logic               r_err_underflow;

    assign w_push_entry = '{pc: push_pc, pred: push_pred, target: push_target};

    // Resolution only ever sees entries stored before this edge.
    assign w_pop       = res_valid && (w_count != '0);
    assign w_underflow = res_valid && (w_count == '0);

    // Wrong direction, or right "taken" direction with the wrong target.
    assign w_mis = w_pop &&
                   ((res_taken != w_head.pred) ||
                    (res_taken && w_head.pred && (res_target != w_head.target)));

    // A push alongside a mispredict is on the wrong path and is dropped.
    assign w_push_ok  = push && !w_mis;
    assign w_overflow = push && w_full && !w_pop;

    assign w_redirect_pc = res_taken ? res_target : (w_head.pc + 32'd4);

    bpred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push_ok),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (w_mis),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_update_en     <= 1'b0;
            r_update_pc     <= '0;
            r_update_taken  <= 1'b0;
            r_redirect      <= 1'b0;
            r_redirect_pc   <= '0;
            r_branch_cnt    <= '0;
            r_mispred_cnt   <= '0;
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            // Every resolution trains the predictor, hit or miss.
            r_update_en <= w_pop;
            if (w_pop) begin
                r_update_pc    <= w_head.pc;
                r_update_taken <= res_taken;
            end

            r_redirect <= w_mis;
            if (w_mis) r_redirect_pc <= w_redirect_pc;

            if (w_pop && (r_branch_cnt != '1))
                r_branch_cnt <= r_branch_cnt + c_stat_one;
            if (w_mis && (r_mispred_cnt != '1))
                r_mispred_cnt <= r_mispred_cnt + c_stat_one;

            if (w_overflow)  r_err_overflow  <= 1'b1;
            if (w_underflow) r_err_underflow <= 1'b1;
        end
    end

    assign full          = w_full;
    assign empty         = w_empty;
    assign update_en     = r_update_en;
    assign update_pc     = r_update_pc;
    assign update_taken  = r_update_taken;
    assign redirect      = r_redirect;
    assign redirect_pc   = r_redirect_pc;
    assign branch_cnt    = r_branch_cnt;
    assign mispred_cnt   = r_mispred_cnt;
    assign err_overflow  = r_err_overflow;
    assign err_underflow = r_err_underflow;

endmodule : bpred_resolve
`default_nettype wire
